trap_controller: RTL and testbench

Machine-mode trap controller for the RISC-V core. Owns mstatus/mie/mtvec/mscratch/mepc/mcause/mip and sequences entry into a trap. Synchronous exceptions from EX are taken in the same cycle. Interrupts are taken via a request → pipeline-flush → jump handshake with the core control block. Drives `any_interrupt_come`, `valid_interrupt_request`, `trap_occurred` and `trap_jump_addr`, and supplies `mepc` to EX for `mret`.

---
 rtl/trap_controller.sv | 177 +++++++++++++++++
 tb/tb_trap_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Machine-mode trap controller: owns the M-mode trap CSRs, takes EX exceptions in
// the same cycle and sequences interrupts through a request/flush/jump handshake.
module trap_controller #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic        exc_illegal,
  input  logic        exc_ecall,
  input  logic        exc_ebreak,
  input  logic        mret_ex,
  input  logic [31:0] pc_ex,
  input  logic        jump_en_ex,
  input  logic [31:0] jump_addr_ex,
  input  logic        stall_n,
  input  logic        flushing_pipeline,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [31:0] mepc,
  output logic        any_interrupt_come,
  output logic        valid_interrupt_request,
  output logic        trap_occurred,
  output logic [31:0] trap_jump_addr
);

  typedef enum logic {IDLE, IRQ_FLUSH} state_t;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  state_t      state;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_msie;
  logic        mie_mtie;
  logic        mie_meie;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [3:0]  irq_code_q;

  logic [31:0] mip_w;
  logic [31:0] mie_w;
  logic [31:0] mstatus_w;
  logic [31:0] pending;
  logic [31:0] tvec_base;
  logic [3:0]  exc_code;
  logic [3:0]  irq_code;
  logic        in_idle;
  logic        exc_raw;
  logic        exc_take;
  logic        irq_take;
  logic        mret_take;
  logic        irq_fire;

  function automatic logic [3:0] irq_prio(input logic [31:0] pend);
    if (pend[11])     irq_prio = 4'd11;
    else if (pend[3]) irq_prio = 4'd3;
    else              irq_prio = 4'd7;
  endfunction

  function automatic logic [3:0] exc_prio(input logic ill, input logic ecall);
    if (ill)        exc_prio = 4'd2;
    else if (ecall) exc_prio = 4'd11;
    else            exc_prio = 4'd3;
  endfunction

  assign mip_w     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
  assign mie_w     = {20'b0, mie_meie, 3'b0, mie_mtie, 3'b0, mie_msie, 3'b0};
  assign mstatus_w = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign pending   = mip_w & mie_w;
  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign exc_code  = exc_prio(exc_illegal, exc_ecall);
  assign irq_code  = irq_prio(pending);

  assign in_idle   = (state == IDLE);
  assign exc_raw   = exc_illegal | exc_ecall | exc_ebreak;
  assign exc_take  = in_idle & exc_raw & ~flushing_pipeline & ~rst_sync;
  assign irq_take  = in_idle & mstatus_mie & (|pending) & stall_n & ~flushing_pipeline
                     & ~exc_raw & ~mret_ex & ~rst_sync;
  assign mret_take = in_idle & mret_ex & ~exc_raw;
  // Reset wins over a pending jump out of IRQ_FLUSH so no stray strobe escapes.
  assign irq_fire  = (state == IRQ_FLUSH) & ~flushing_pipeline & ~rst_sync;

  assign any_interrupt_come      = |pending;
  assign valid_interrupt_request = irq_take;
  assign trap_occurred           = exc_take | irq_fire;
  assign trap_jump_addr          = ((state == IRQ_FLUSH) && (mtvec_q[1:0] == 2'b01))
                                   ? tvec_base + {26'b0, irq_code_q, 2'b00}
                                   : tvec_base;
  assign mepc                    = mepc_q;

  always_comb begin
    csr_rdata = 32'b0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rdata = mstatus_w;
      ADDR_MIE:      csr_rdata = mie_w;
      ADDR_MTVEC:    csr_rdata = mtvec_q;
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MIP:      csr_rdata = mip_w;
      default:       csr_rdata = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state        <= IDLE;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_msie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= 32'b0;
      mepc_q       <= 32'b0;
      mcause_q     <= 32'b0;
      irq_code_q   <= 4'b0;
    end else begin
      case (state)
        IDLE:      if (irq_take) state <= IRQ_FLUSH;
        IRQ_FLUSH: if (!flushing_pipeline) state <= IDLE;
        default:   state <= IDLE;
      endcase

      // Software writes first so that trap/mret updates below take precedence.
      if (in_idle && csr_we) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          ADDR_MIE: begin
            mie_msie <= csr_wdata[3];
            mie_mtie <= csr_wdata[7];
            mie_meie <= csr_wdata[11];
          end
          ADDR_MTVEC:    mtvec_q    <= csr_wdata;
          ADDR_MSCRATCH: mscratch_q <= csr_wdata;
          ADDR_MEPC:     mepc_q     <= {csr_wdata[31:2], 2'b00};
          ADDR_MCAUSE:   mcause_q   <= csr_wdata;
          default:       ;
        endcase
      end

      if (exc_take) begin
        mepc_q       <= {pc_ex[31:2], 2'b00};
        mcause_q     <= {28'b0, exc_code};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (irq_take) begin
        mepc_q       <= jump_en_ex ? {jump_addr_ex[31:2], 2'b00}
                                   : {pc_ex[31:2] + 30'd1, 2'b00};
        mcause_q     <= {1'b1, 27'b0, irq_code};
        irq_code_q   <= irq_code;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_take) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: CSR reset values, exceptions, interrupt
// handshake, priorities, mret and reset during the flush window.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic        irq_ext, irq_timer, irq_soft;
  logic        exc_illegal, exc_ecall, exc_ebreak;
  logic        mret_ex;
  logic [31:0] pc_ex;
  logic        jump_en_ex;
  logic [31:0] jump_addr_ex;
  logic        stall_n, flushing_pipeline;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] mepc;
  logic        any_interrupt_come, valid_interrupt_request, trap_occurred;
  logic [31:0] trap_jump_addr;

  int n_cmp = 0;
  int n_err = 0;

  trap_controller #(.MTVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .rst_sync(rst_sync),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .exc_illegal(exc_illegal), .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak),
    .mret_ex(mret_ex), .pc_ex(pc_ex),
    .jump_en_ex(jump_en_ex), .jump_addr_ex(jump_addr_ex),
    .stall_n(stall_n), .flushing_pipeline(flushing_pipeline),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .mepc(mepc),
    .any_interrupt_come(any_interrupt_come),
    .valid_interrupt_request(valid_interrupt_request),
    .trap_occurred(trap_occurred), .trap_jump_addr(trap_jump_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_we = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  task automatic csr_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  initial begin
    rst_sync = 1'b1;
    {irq_ext, irq_timer, irq_soft} = 3'b000;
    {exc_illegal, exc_ecall, exc_ebreak} = 3'b000;
    mret_ex = 1'b0; pc_ex = 32'h0; jump_en_ex = 1'b0; jump_addr_ex = 32'h0;
    stall_n = 1'b1; flushing_pipeline = 1'b0;
    csr_addr = 12'h0; csr_we = 1'b0; csr_wdata = 32'h0;
    step(); step();
    rst_sync = 1'b0;
    #1;

    // Reset values
    csr_check("rst_mtvec",    12'h305, 32'h0000_0100);
    csr_check("rst_mstatus",  12'h300, 32'h0000_1800);
    csr_check("rst_mie",      12'h304, 32'h0);
    csr_check("rst_mscratch", 12'h340, 32'h0);
    csr_check("rst_mepc",     12'h341, 32'h0);
    csr_check("rst_mcause",   12'h342, 32'h0);
    csr_check("rst_mip",      12'h344, 32'h0);
    csr_check("rst_unimpl",   12'h7C0, 32'h0);
    check("rst_trap",  {31'b0, trap_occurred}, 32'h0);
    check("rst_vreq",  {31'b0, valid_interrupt_request}, 32'h0);

    // ecall with MIE=1 beforehand
    csr_write(12'h300, 32'h0000_0008);
    pc_ex = 32'h200; exc_ecall = 1'b1;
    #1;
    check("ecall_trap", {31'b0, trap_occurred}, 32'h1);
    check("ecall_addr", trap_jump_addr, 32'h100);
    check("ecall_vreq", {31'b0, valid_interrupt_request}, 32'h0);
    step();
    exc_ecall = 1'b0;
    #1;
    check("ecall_trap_off", {31'b0, trap_occurred}, 32'h0);
    check("ecall_mepc", mepc, 32'h200);
    csr_check("ecall_mcause",  12'h342, 32'd11);
    csr_check("ecall_mstatus", 12'h300, 32'h0000_1880);

    // Timer interrupt, vectored mode, flush for two cycles
    csr_write(12'h305, 32'h0000_0101);
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h300, 32'h0000_0008);
    pc_ex = 32'h40; irq_timer = 1'b1;
    #1;
    check("tmr_any",  {31'b0, any_interrupt_come}, 32'h1);
    check("tmr_vreq", {31'b0, valid_interrupt_request}, 32'h1);
    check("tmr_trap_T", {31'b0, trap_occurred}, 32'h0);
    step();                                   // T+1
    irq_timer = 1'b0; flushing_pipeline = 1'b1;
    csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF; csr_we = 1'b1;
    #1;
    check("tmr_trap_T1", {31'b0, trap_occurred}, 32'h0);
    check("tmr_vreq_T1", {31'b0, valid_interrupt_request}, 32'h0);
    check("tmr_mepc", mepc, 32'h44);
    csr_check("tmr_mcause",  12'h342, 32'h8000_0007);
    csr_check("tmr_mstatus", 12'h300, 32'h0000_1880);
    csr_addr = 12'h340;
    step();                                   // T+2
    csr_we = 1'b0;
    #1;
    check("tmr_trap_T2", {31'b0, trap_occurred}, 32'h0);
    csr_check("flush_csr_ignored", 12'h340, 32'h0);
    step();                                   // T+3
    flushing_pipeline = 1'b0;
    #1;
    check("tmr_trap_T3", {31'b0, trap_occurred}, 32'h1);
    check("tmr_addr", trap_jump_addr, 32'h11C);
    step();
    check("tmr_trap_T4", {31'b0, trap_occurred}, 32'h0);

    // External beats timer, jump target becomes mepc
    csr_write(12'h304, 32'h0000_0880);
    csr_write(12'h300, 32'h0000_0008);
    irq_ext = 1'b1; irq_timer = 1'b1; jump_en_ex = 1'b1; jump_addr_ex = 32'h300; pc_ex = 32'h80;
    #1;
    check("ext_vreq", {31'b0, valid_interrupt_request}, 32'h1);
    step();
    irq_ext = 1'b0; irq_timer = 1'b0; jump_en_ex = 1'b0;
    #1;
    check("ext_trap", {31'b0, trap_occurred}, 32'h1);
    check("ext_addr", trap_jump_addr, 32'h12C);
    check("ext_mepc", mepc, 32'h300);
    csr_check("ext_mcause", 12'h342, 32'h8000_000B);
    step();

    // mret restores MIE from MPIE
    mret_ex = 1'b1;
    #1;
    check("mret_vreq", {31'b0, valid_interrupt_request}, 32'h0);
    step();
    mret_ex = 1'b0;
    csr_check("mret_mstatus", 12'h300, 32'h0000_1888);

    // Exception beats a pending interrupt
    irq_timer = 1'b1; exc_illegal = 1'b1; pc_ex = 32'h500;
    #1;
    check("ill_trap", {31'b0, trap_occurred}, 32'h1);
    check("ill_vreq", {31'b0, valid_interrupt_request}, 32'h0);
    check("ill_addr", trap_jump_addr, 32'h100);
    step();
    exc_illegal = 1'b0;
    #1;
    check("ill_mepc", mepc, 32'h500);
    csr_check("ill_mcause", 12'h342, 32'd2);
    check("ill_blocked_vreq", {31'b0, valid_interrupt_request}, 32'h0);
    check("ill_any", {31'b0, any_interrupt_come}, 32'h1);

    // Reset while in IRQ_FLUSH
    csr_write(12'h300, 32'h0000_0008);
    #1;
    check("rf_vreq", {31'b0, valid_interrupt_request}, 32'h1);
    step();
    flushing_pipeline = 1'b1;
    step();
    rst_sync = 1'b1; flushing_pipeline = 1'b0;
    #1;
    check("rf_trap_in_rst", {31'b0, trap_occurred}, 32'h0);
    step();
    rst_sync = 1'b0; irq_timer = 1'b0;
    #1;
    check("rf_trap_after", {31'b0, trap_occurred}, 32'h0);
    check("rf_vreq_after", {31'b0, valid_interrupt_request}, 32'h0);
    csr_check("rf_mtvec",   12'h305, 32'h0000_0100);
    csr_check("rf_mstatus", 12'h300, 32'h0000_1800);
    // Back in IDLE: an ebreak must be taken immediately
    exc_ebreak = 1'b1;
    #1;
    check("rf_idle_trap", {31'b0, trap_occurred}, 32'h1);
    step();
    exc_ebreak = 1'b0;
    csr_check("ebreak_mcause", 12'h342, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
